full_st1_tap_arb: RTL and testbench

//  Arbiter and sequencer for the single-port stage-1 tap memory (tap_int, 192b x 32).

---
 rtl/full_st1_pkg.sv | 21 ++
 rtl/full_st1_tap_rd_route.sv | 41 ++++
 rtl/full_st1_tap_arb.sv | 156 +++++++++++++++
 tb/tb_full_st1_tap_arb.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/full_st1_pkg.sv
// Shared types and defaults for the stage-1 tap memory arbiter and its read-return path.
package full_st1_pkg;

   typedef logic [191:0] tap_word_t;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   typedef enum logic {
      TAG_FW = 1'b0,
      TAG_UP = 1'b1
   } rd_tag_t;

   localparam int TAP_AW_DEF     = 5;
   localparam int TAP_DW_DEF     = $bits(tap_word_t);
   localparam int STARVE_MAX_DEF = 4;
   localparam int LOCK_MAX_DEF   = 15;

endpackage

// File: rtl/full_st1_tap_rd_route.sv
// Read-return path: registers which requester owns the read issued this cycle and steers
// the RAM output (one cycle later) to that requester's valid.
module full_st1_tap_rd_route
   import full_st1_pkg::*;
#(
   parameter int DW = TAP_DW_DEF
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          rd_issue_i,
   input  rd_tag_t       rd_tag_i,
   input  logic [DW-1:0] mem_rd_data_i,
   output logic          fw_rd_vld_o,
   output logic [DW-1:0] fw_rd_data_o,
   output logic          up_rd_vld_o,
   output logic [DW-1:0] up_rd_data_o
);

   logic    vld_q;
   rd_tag_t tag_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= 1'b0;
         tag_q <= TAG_FW;
      end else begin
         vld_q <= rd_issue_i;
         if (rd_issue_i) begin
            tag_q <= rd_tag_i;
         end
      end
   end

   assign fw_rd_vld_o = vld_q && (tag_q == TAG_FW);
   assign up_rd_vld_o = vld_q && (tag_q == TAG_UP);

   // Data is only meaningful under its valid, so both consumers see the raw RAM output.
   assign fw_rd_data_o = mem_rd_data_i;
   assign up_rd_data_o = mem_rd_data_i;

endmodule

// File: rtl/full_st1_tap_arb.sv
// Single-port arbiter for the stage-1 tap RAM: tap loader writes, forward reads and
// locked read-modify-write for the error-update engine, with starvation and lock timeouts.
module full_st1_tap_arb
   import full_st1_pkg::*;
#(
   parameter int AW         = TAP_AW_DEF,
   parameter int DW         = TAP_DW_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          ld_req_i,
   input  logic [AW-1:0] ld_addr_i,
   input  logic [DW-1:0] ld_data_i,
   output logic          ld_gnt_o,
   input  logic          fw_req_i,
   input  logic [AW-1:0] fw_addr_i,
   output logic          fw_gnt_o,
   output logic          fw_rd_vld_o,
   output logic [DW-1:0] fw_rd_data_o,
   input  logic          up_req_i,
   input  logic [AW-1:0] up_addr_i,
   output logic          up_gnt_o,
   output logic          up_rd_vld_o,
   output logic [DW-1:0] up_rd_data_o,
   input  logic          up_wr_vld_i,
   input  logic [DW-1:0] up_wr_data_i,
   output logic          up_abort_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wr_data_o,
   input  logic [DW-1:0] mem_rd_data_i
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int LW = $clog2(LOCK_MAX + 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
   localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_MAX - 1);

   arb_state_t    state_q,      state_d;
   logic [AW-1:0] lock_addr_q,  lock_addr_d;
   logic [LW-1:0] lock_cnt_q,   lock_cnt_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;

   logic fw_sel, ld_sel, up_sel, wb_sel, abort_sel;
   logic fw_cand, ld_cand, fw_starved, in_lock;

   assign in_lock    = (state_q == LOCK);
   assign fw_starved = (starve_cnt_q == STARVE_TOP);
   assign fw_cand    = fw_req_i && !(in_lock && (fw_addr_i == lock_addr_q));
   assign ld_cand    = ld_req_i && !(in_lock && (ld_addr_i == lock_addr_q));

   always_comb begin
      fw_sel      = 1'b0;
      ld_sel      = 1'b0;
      up_sel      = 1'b0;
      wb_sel      = 1'b0;
      abort_sel   = 1'b0;
      state_d     = state_q;
      lock_addr_d = lock_addr_q;
      lock_cnt_d  = lock_cnt_q;

      if (in_lock && up_wr_vld_i) begin
         // The locked write-back takes the port outright and beats a same-cycle timeout.
         wb_sel  = 1'b1;
         state_d = ARB;
      end else begin
         if (fw_cand && fw_starved) begin
            fw_sel = 1'b1;
         end else if (ld_cand) begin
            ld_sel = 1'b1;
         end else if (!in_lock && up_req_i) begin
            up_sel      = 1'b1;
            state_d     = LOCK;
            lock_addr_d = up_addr_i;
            lock_cnt_d  = '0;
         end else if (fw_cand) begin
            fw_sel = 1'b1;
         end

         if (in_lock) begin
            lock_cnt_d = lock_cnt_q + LW'(1);
            if (lock_cnt_q == LOCK_LAST) begin
               abort_sel = 1'b1;
               state_d   = ARB;
            end
         end
      end
   end

   always_comb begin
      starve_cnt_d = '0;
      if (fw_req_i && !fw_sel) begin
         starve_cnt_d = fw_starved ? starve_cnt_q : starve_cnt_q + SW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ARB;
         lock_addr_q  <= '0;
         lock_cnt_q   <= '0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         lock_addr_q  <= lock_addr_d;
         lock_cnt_q   <= lock_cnt_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Grants are combinational, so they are masked while reset is held to keep the RAM idle.
   assign ld_gnt_o   = ld_sel    && rst_ni;
   assign fw_gnt_o   = fw_sel    && rst_ni;
   assign up_gnt_o   = up_sel    && rst_ni;
   assign up_abort_o = abort_sel && rst_ni;

   logic wb_gnt;
   assign wb_gnt = wb_sel && rst_ni;

   assign mem_en_o = ld_gnt_o || fw_gnt_o || up_gnt_o || wb_gnt;
   assign mem_we_o = ld_gnt_o || wb_gnt;

   always_comb begin
      mem_addr_o    = '0;
      mem_wr_data_o = '0;
      if (wb_gnt) begin
         mem_addr_o    = lock_addr_q;
         mem_wr_data_o = up_wr_data_i;
      end else if (ld_gnt_o) begin
         mem_addr_o    = ld_addr_i;
         mem_wr_data_o = ld_data_i;
      end else if (fw_gnt_o) begin
         mem_addr_o = fw_addr_i;
      end else if (up_gnt_o) begin
         mem_addr_o = up_addr_i;
      end
   end

   full_st1_tap_rd_route #(
      .DW(DW)
   ) u_rd_route (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .rd_issue_i    (fw_gnt_o || up_gnt_o),
      .rd_tag_i      (up_gnt_o ? TAG_UP : TAG_FW),
      .mem_rd_data_i (mem_rd_data_i),
      .fw_rd_vld_o   (fw_rd_vld_o),
      .fw_rd_data_o  (fw_rd_data_o),
      .up_rd_vld_o   (up_rd_vld_o),
      .up_rd_data_o  (up_rd_data_o)
   );

endmodule

// File: tb/tb_full_st1_tap_arb.sv
// Scenario bench for full_st1_tap_arb with a write-first RAM model and read-data scoreboard.
module tb_full_st1_tap_arb;
   import full_st1_pkg::*;

   localparam int AW = 5;
   localparam int DW = 192;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          ld_req_i = 1'b0, fw_req_i = 1'b0, up_req_i = 1'b0, up_wr_vld_i = 1'b0;
   logic [AW-1:0] ld_addr_i = '0, fw_addr_i = '0, up_addr_i = '0;
   tap_word_t     ld_data_i = '0, up_wr_data_i = '0;
   logic          ld_gnt_o, fw_gnt_o, up_gnt_o, fw_rd_vld_o, up_rd_vld_o, up_abort_o;
   logic          mem_en_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   tap_word_t     fw_rd_data_o, up_rd_data_o, mem_wr_data_o, mem_rd_data_i;

   int tests = 0;
   int fails = 0;

   tap_word_t ram [32];
   tap_word_t ram_rd_q = '0;
   tap_word_t exp_mem [32];
   tap_word_t fwq [$];
   tap_word_t upq [$];
   tap_word_t fw_exp, up_exp;

   always #5 clk_i = ~clk_i;

   full_st1_tap_arb #(.AW(AW), .DW(DW), .STARVE_MAX(4), .LOCK_MAX(15)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i), .ld_gnt_o(ld_gnt_o),
      .fw_req_i(fw_req_i), .fw_addr_i(fw_addr_i), .fw_gnt_o(fw_gnt_o),
      .fw_rd_vld_o(fw_rd_vld_o), .fw_rd_data_o(fw_rd_data_o),
      .up_req_i(up_req_i), .up_addr_i(up_addr_i), .up_gnt_o(up_gnt_o),
      .up_rd_vld_o(up_rd_vld_o), .up_rd_data_o(up_rd_data_o),
      .up_wr_vld_i(up_wr_vld_i), .up_wr_data_i(up_wr_data_i), .up_abort_o(up_abort_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wr_data_o(mem_wr_data_o), .mem_rd_data_i(mem_rd_data_i)
   );

   // Write-first single-port RAM with one cycle of read latency.
   always @(posedge clk_i) begin
      if (mem_en_o) begin
         if (mem_we_o) begin
            ram[mem_addr_o] <= mem_wr_data_o;
            ram_rd_q        <= mem_wr_data_o;
         end else begin
            ram_rd_q <= ram[mem_addr_o];
         end
      end
   end
   assign mem_rd_data_i = ram_rd_q;

   // Scoreboard: every returned read must match the oldest expected value for that requester.
   always @(negedge clk_i) begin
      if (fw_rd_vld_o) begin
         tests++;
         if (fwq.size() == 0) begin
            fails++;
            $display("FAIL fw_rd_unexpected: fw_rd_vld=1 with no read outstanding");
         end else begin
            fw_exp = fwq.pop_front();
            if (fw_rd_data_o !== fw_exp) begin
               fails++;
               $display("FAIL fw_rd_data: got %h want %h", fw_rd_data_o, fw_exp);
            end
         end
      end
      if (up_rd_vld_o) begin
         tests++;
         if (upq.size() == 0) begin
            fails++;
            $display("FAIL up_rd_unexpected: up_rd_vld=1 with no read outstanding");
         end else begin
            up_exp = upq.pop_front();
            if (up_rd_data_o !== up_exp) begin
               fails++;
               $display("FAIL up_rd_data: got %h want %h", up_rd_data_o, up_exp);
            end
         end
      end
   end

   function automatic tap_word_t mk(input logic [31:0] s);
      return {6{s}};
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      ld_req_i    = 1'b0;
      fw_req_i    = 1'b0;
      up_req_i    = 1'b0;
      up_wr_vld_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      ld_req_i = 1'b1; ld_addr_i = 5'd4; ld_data_i = mk(32'hdead0004);
      fw_req_i = 1'b1; fw_addr_i = 5'd6;
      up_req_i = 1'b1; up_addr_i = 5'd8;
      up_wr_vld_i = 1'b1;
      @(negedge clk_i);
      tests++;
      if ({ld_gnt_o, fw_gnt_o, up_gnt_o, up_abort_o, fw_rd_vld_o, up_rd_vld_o, mem_en_o, mem_we_o} !== 8'h00) begin
         fails++;
         $display("FAIL reset_ctrl: got %b want 00000000",
                  {ld_gnt_o, fw_gnt_o, up_gnt_o, up_abort_o, fw_rd_vld_o, up_rd_vld_o, mem_en_o, mem_we_o});
      end
      tests++;
      if (mem_addr_o !== 5'd0) begin
         fails++;
         $display("FAIL reset_addr: got %0d want 0", mem_addr_o);
      end
      idle();
      tick();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_load_read();
      tap_word_t d;
      d = mk(32'h3a3a0003);
      ld_req_i = 1'b1; ld_addr_i = 5'd3; ld_data_i = d;
      @(negedge clk_i);
      tests++;
      if ({ld_gnt_o, mem_en_o, mem_we_o, fw_gnt_o, up_gnt_o} !== 5'b11100) begin
         fails++;
         $display("FAIL load_gnt: got %b want 11100", {ld_gnt_o, mem_en_o, mem_we_o, fw_gnt_o, up_gnt_o});
      end
      tests++;
      if (mem_addr_o !== 5'd3 || mem_wr_data_o !== d) begin
         fails++;
         $display("FAIL load_mem: addr %0d data %h want addr 3 data %h", mem_addr_o, mem_wr_data_o, d);
      end
      exp_mem[3] = d;
      tick();
      ld_req_i = 1'b0; fw_req_i = 1'b1; fw_addr_i = 5'd3;
      @(negedge clk_i);
      tests++;
      if ({fw_gnt_o, mem_en_o, mem_we_o} !== 3'b110 || mem_addr_o !== 5'd3) begin
         fails++;
         $display("FAIL fw_gnt_raw: gnt/en/we %b addr %0d want 110 addr 3", {fw_gnt_o, mem_en_o, mem_we_o}, mem_addr_o);
      end
      fwq.push_back(exp_mem[3]);
      tick();
      fw_req_i = 1'b0;
      @(negedge clk_i);
      tests++;
      if (fw_rd_vld_o !== 1'b1 || up_rd_vld_o !== 1'b0) begin
         fails++;
         $display("FAIL fw_rd_vld_lat: fw_vld %b up_vld %b want 1 0", fw_rd_vld_o, up_rd_vld_o);
      end
      tick();
      // Preload addresses used by the lock scenarios.
      for (int i = 0; i < 2; i++) begin
         ld_req_i  = 1'b1;
         ld_addr_i = (i == 0) ? 5'd2 : 5'd7;
         ld_data_i = mk(32'h5050_0000 + 32'(i));
         @(negedge clk_i);
         tests++;
         if (ld_gnt_o !== 1'b1 || mem_addr_o !== ld_addr_i) begin
            fails++;
            $display("FAIL preload_gnt: gnt %b addr %0d want 1 addr %0d", ld_gnt_o, mem_addr_o, ld_addr_i);
         end
         exp_mem[ld_addr_i] = ld_data_i;
         tick();
      end
      idle();
   endtask

   task automatic test_starvation();
      tap_word_t d;
      logic exp_fw;
      d = mk(32'h0a0a000a);
      ld_req_i = 1'b1; ld_addr_i = 5'd10; ld_data_i = d;
      fw_req_i = 1'b1; fw_addr_i = 5'd3;
      for (int i = 0; i < 10; i++) begin
         exp_fw = (i == 4) || (i == 9);
         @(negedge clk_i);
         tests++;
         if (fw_gnt_o !== exp_fw || ld_gnt_o !== !exp_fw) begin
            fails++;
            $display("FAIL starve_seq[%0d]: fw %b ld %b want fw %b ld %b", i, fw_gnt_o, ld_gnt_o, exp_fw, !exp_fw);
         end
         if (exp_fw) fwq.push_back(exp_mem[3]);
         tick();
      end
      exp_mem[10] = d;
      idle();
      @(negedge clk_i);
      tick();
   endtask

   task automatic test_lock();
      tap_word_t w7;
      w7 = mk(32'h77770007);
      up_req_i = 1'b1; up_addr_i = 5'd7;
      @(negedge clk_i);
      tests++;
      if ({up_gnt_o, mem_en_o, mem_we_o} !== 3'b110 || mem_addr_o !== 5'd7) begin
         fails++;
         $display("FAIL up_gnt: gnt/en/we %b addr %0d want 110 addr 7", {up_gnt_o, mem_en_o, mem_we_o}, mem_addr_o);
      end
      upq.push_back(exp_mem[7]);
      tick();
      up_addr_i = 5'd9;
      fw_req_i = 1'b1; fw_addr_i = 5'd7;
      ld_req_i = 1'b1; ld_addr_i = 5'd7; ld_data_i = mk(32'hbad00007);
      @(negedge clk_i);
      tests++;
      if (up_rd_vld_o !== 1'b1) begin
         fails++;
         $display("FAIL up_rd_vld_lat: got %b want 1", up_rd_vld_o);
      end
      tests++;
      if ({fw_gnt_o, ld_gnt_o, up_gnt_o, mem_en_o} !== 4'b0000) begin
         fails++;
         $display("FAIL lock_block: fw/ld/up/en %b want 0000", {fw_gnt_o, ld_gnt_o, up_gnt_o, mem_en_o});
      end
      tick();
      up_req_i = 1'b0; fw_addr_i = 5'd2;
      @(negedge clk_i);
      tests++;
      if (fw_gnt_o !== 1'b1 || ld_gnt_o !== 1'b0 || mem_addr_o !== 5'd2) begin
         fails++;
         $display("FAIL lock_other_addr: fw %b ld %b addr %0d want 1 0 addr 2", fw_gnt_o, ld_gnt_o, mem_addr_o);
      end
      fwq.push_back(exp_mem[2]);
      tick();
      ld_req_i = 1'b0; fw_addr_i = 5'd7;
      up_wr_vld_i = 1'b1; up_wr_data_i = w7;
      @(negedge clk_i);
      tests++;
      if ({mem_en_o, mem_we_o, fw_gnt_o} !== 3'b110 || mem_addr_o !== 5'd7 || mem_wr_data_o !== w7) begin
         fails++;
         $display("FAIL writeback: en/we/fw %b addr %0d data %h want 110 addr 7 data %h",
                  {mem_en_o, mem_we_o, fw_gnt_o}, mem_addr_o, mem_wr_data_o, w7);
      end
      exp_mem[7] = w7;
      tick();
      up_wr_vld_i = 1'b0;
      @(negedge clk_i);
      tests++;
      if (fw_gnt_o !== 1'b1 || mem_addr_o !== 5'd7 || mem_we_o !== 1'b0) begin
         fails++;
         $display("FAIL fw_after_wb: fw %b we %b addr %0d want 1 0 addr 7", fw_gnt_o, mem_we_o, mem_addr_o);
      end
      fwq.push_back(exp_mem[7]);
      tick();
      idle();
      @(negedge clk_i);
      tick();
   endtask

   task automatic test_abort();
      tap_word_t w9;
      w9 = mk(32'h99990009);
      up_req_i = 1'b1; up_addr_i = 5'd9;
      @(negedge clk_i);
      tests++;
      if (up_gnt_o !== 1'b1) begin
         fails++;
         $display("FAIL abort_up_gnt: got %b want 1", up_gnt_o);
      end
      upq.push_back(exp_mem[9]);
      tick();
      up_req_i = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk_i);
         tests++;
         if (up_abort_o !== (i == 15) || mem_en_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_timing[%0d]: abort %b en %b want %b 0", i, up_abort_o, mem_en_o, (i == 15));
         end
         tick();
      end
      up_wr_vld_i = 1'b1; up_wr_data_i = mk(32'hbad00009);
      @(negedge clk_i);
      tests++;
      if ({mem_en_o, mem_we_o, up_abort_o} !== 3'b000) begin
         fails++;
         $display("FAIL late_wb_ignored: en/we/abort %b want 000", {mem_en_o, mem_we_o, up_abort_o});
      end
      tick();
      up_wr_vld_i = 1'b0;
      // Write-back on the final lock cycle must win over the timeout.
      up_req_i = 1'b1;
      @(negedge clk_i);
      upq.push_back(exp_mem[9]);
      tick();
      up_req_i = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         if (i == 15) begin
            up_wr_vld_i = 1'b1; up_wr_data_i = w9;
         end
         @(negedge clk_i);
         tests++;
         if (up_abort_o !== 1'b0 || mem_we_o !== (i == 15)) begin
            fails++;
            $display("FAIL wb_vs_abort[%0d]: abort %b we %b want 0 %b", i, up_abort_o, mem_we_o, (i == 15));
         end
         tick();
      end
      exp_mem[9] = w9;
      up_wr_vld_i = 1'b0;
      fw_req_i = 1'b1; fw_addr_i = 5'd9;
      @(negedge clk_i);
      tests++;
      if (fw_gnt_o !== 1'b1) begin
         fails++;
         $display("FAIL fw_after_abort: got %b want 1", fw_gnt_o);
      end
      fwq.push_back(exp_mem[9]);
      tick();
      idle();
      @(negedge clk_i);
      tick();
   endtask

   task automatic test_reset_mid_lock();
      up_req_i = 1'b1; up_addr_i = 5'd2;
      @(negedge clk_i);
      tests++;
      if (up_gnt_o !== 1'b1) begin
         fails++;
         $display("FAIL rst_lock_up_gnt: got %b want 1", up_gnt_o);
      end
      tick();
      up_req_i = 1'b0;
      rst_ni = 1'b0;
      fw_req_i = 1'b1; fw_addr_i = 5'd5;
      up_wr_vld_i = 1'b1; up_wr_data_i = mk(32'hbad00002);
      @(negedge clk_i);
      tests++;
      if ({fw_gnt_o, up_gnt_o, ld_gnt_o, up_abort_o, fw_rd_vld_o, up_rd_vld_o, mem_en_o, mem_we_o} !== 8'h00
          || mem_addr_o !== 5'd0) begin
         fails++;
         $display("FAIL rst_mid_lock: ctrl %b addr %0d want 00000000 addr 0",
                  {fw_gnt_o, up_gnt_o, ld_gnt_o, up_abort_o, fw_rd_vld_o, up_rd_vld_o, mem_en_o, mem_we_o}, mem_addr_o);
      end
      tick();
      tick();
      rst_ni = 1'b1;
      @(negedge clk_i);
      tests++;
      if (fw_gnt_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 5'd5) begin
         fails++;
         $display("FAIL post_rst_gnt: fw %b we %b addr %0d want 1 0 addr 5", fw_gnt_o, mem_we_o, mem_addr_o);
      end
      fwq.push_back(exp_mem[5]);
      tick();
      idle();
      @(negedge clk_i);
      tests++;
      if (fw_rd_vld_o !== 1'b1) begin
         fails++;
         $display("FAIL post_rst_rd_vld: got %b want 1", fw_rd_vld_o);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 32; i++) begin
         ram[i]     = '0;
         exp_mem[i] = '0;
      end
      test_reset();
      test_load_read();
      test_starvation();
      test_lock();
      test_abort();
      test_reset_mid_lock();
      tick();
      tests++;
      if (fwq.size() != 0 || upq.size() != 0) begin
         fails++;
         $display("FAIL reads_outstanding: fw %0d up %0d want 0 0", fwq.size(), upq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
